obi_data_responder: RTL and testbench
=====================================

Name: obi_data_responder

Overview:
- Memory-side responder for the accelerator's OBI-style data port (req/gnt/rvalid).
- Answers the requests issued by the vector LSU.
- Provides a word-organised local data RAM with byte-enable writes, a fixed response latency, bounded outstanding transactions and an externally driven grant stall.
- Used as the accelerator's scratch/data memory in SoC integration and as the reference memory model on the verification bench.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two, >= 2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS)
LATENCY, 1, cycles from accepted request to rvalid (1..4)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..LATENCY+1)

Ports:
clk  in  1  clock, all state on rising edge
n_reset  in  1  asynchronous active-low reset
data_req_i  in  1  request valid from initiator
data_gnt_o  out  1  request accepted this cycle (combinational)
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  4  byte enables, bit n = byte lane n (bits [8n+7:8n])
data_addr_i  in  32  byte address; bits [1:0] ignored
data_wdata_i  in  32  write data
data_rvalid_o  out  1  response valid, one cycle per accepted request
data_rdata_o  out  32  read data; 0 when rvalid low or for writes/errors
data_err_o  out  1  response error, valid with rvalid
stall_i  in  1  force data_gnt_o low (bench backpressure / arbitration)

Behaviour:
- Reset (n_reset low, asynchronous):
  - rvalid, rdata and err go to 0.
  - Outstanding counter and the response pipeline are cleared; pending responses are discarded, not replayed.
  - RAM contents are not reset.
  - data_gnt_o is 0 while n_reset is low.
- Grant: data_gnt_o = data_req_i-independent; gnt = n_reset & !stall_i & (outstanding < MAX_OUTSTANDING). Acceptance = data_req_i & data_gnt_o.
- Address decode:
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
  - Word index = (addr - BASE_ADDR) >> 2.
  - Out of range: access is accepted normally and answered with err=1 and rdata=0; writes are dropped.
- Write:
  - RAM is updated on the accept edge, for enabled byte lanes only.
  - be=0000 is legal and changes nothing.
  - Response: rvalid with rdata=0, err=0 (or err=1 if out of range).
- Read:
  - RAM word is sampled on the accept edge; data_be_i is ignored and the full word is returned.
  - A read accepted in the cycle after a write to the same word returns the new data (write-then-read ordering holds).
- Latency: the response for a request accepted at edge k appears with rvalid=1 during the cycle after edge k+LATENCY-1.
  - For LATENCY=1: rvalid is high the cycle immediately after acceptance.
- Pipeline: a LATENCY-deep shift pipeline carries {valid, err, rdata}. Responses are in order, at most one rvalid per cycle, and one accept per cycle. No rready: the initiator must take the response when rvalid is high.
- Outstanding counter:
  - +1 on accept, -1 on rvalid; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING, because gnt is low at the limit.
  - At the limit, gnt reasserts in the same cycle that rvalid frees a slot only via the registered count, i.e. the next cycle.
- stall_i:
  - Only blocks new acceptances; in-flight responses still complete.
  - The initiator holds req, addr, we, be and wdata stable until gnt (OBI rule); the responder does not check this.
- Back-to-back: with MAX_OUTSTANDING >= LATENCY+1 and stall_i low, one request per cycle is sustained indefinitely.
- Address wrap: none. Addresses past the top of the RAM are errors and do not wrap to index 0.

Test Plan:
1. Reset, then write 0xDEADBEEF to BASE+0x10 with be=1111, then read BASE+0x10 → gnt in the request cycle; write rvalid after LATENCY with rdata 0 and err 0; read rvalid returns 0xDEADBEEF.
2. Partial write: word holds 0x11223344; write 0xAABBCCDD with be=0101 → a subsequent read returns 0x11BB33DD.
3. Streaming: LATENCY=2, MAX_OUTSTANDING=3, 8 back-to-back reads of preloaded words 0..7 → gnt held high throughout, rvalid high for 8 consecutive cycles starting 2 cycles after the first accept, data in order.
4. Backpressure: LATENCY=3, MAX_OUTSTANDING=1, 3 queued reads → gnt low for the cycles after each accept until the matching rvalid, giving one accept every 4 cycles; stall_i=1 for 5 cycles holds gnt low while the pending rvalid still arrives.
5. Out of range: write to BASE+4*DEPTH_WORDS, then read of the same address → both responses have err=1 and rdata=0; word 0 is unchanged, confirming no wrap.
6. Reset mid-flight: accept 2 reads with LATENCY=3 and assert n_reset low one cycle later → rvalid stays 0 and is never produced for those reads; after release gnt=1 and the outstanding count is 0, so MAX_OUTSTANDING requests are accepted at once.

Source files
------------

// File: rtl/obi_data_if.sv
// OBI-style data port bundle between the vector LSU (master) and a memory responder (slave).
interface obi_data_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/obi_data_responder.sv
// Word-organised data RAM answering OBI req/gnt/rvalid traffic with a fixed response
// latency, a bounded number of outstanding transactions and an external grant stall.
module obi_data_responder #(
  parameter int          DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       stall_i,
  obi_data_if.slave  bus
);
  localparam int               DATA_W  = 32;
  localparam int               IDX_W   = $clog2(DEPTH_WORDS);
  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0]      SPAN    = 33'(DEPTH_WORDS) << 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [32:0]       offset;
  logic              in_range;
  logic              accept;
  logic              wr_en;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rd_word;

  logic [LATENCY-1:0]             vld_q, vld_d;
  logic [LATENCY-1:0]             err_q, err_d;
  logic [LATENCY-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  // Grant depends only on reset, stall and the registered outstanding count, never on req.
  assign bus.data_gnt_o = n_reset & ~stall_i & (cnt_q < MAX_CNT);
  assign accept         = bus.data_req_i & bus.data_gnt_o;

  // 33-bit difference so addresses below the base land far above SPAN instead of wrapping.
  assign offset   = {1'b0, bus.data_addr_i} - {1'b0, BASE_ADDR};
  assign in_range = offset < SPAN;
  assign word_idx = offset[IDX_W+1:2];
  assign wr_en    = accept & bus.data_we_i & in_range;
  assign rd_word  = mem[word_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) mem[word_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    vld_d   = vld_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    // stage 0: capture the accepted request's response
    vld_d[0]   = accept;
    err_d[0]   = accept & ~in_range;
    rdata_d[0] = (accept & ~bus.data_we_i & in_range) ? rd_word : '0;
    // stages 1..LATENCY-1: plain shift toward the output
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      err_d[i]   = err_q[i-1];
      rdata_d[i] = rdata_q[i-1];
    end
    case ({accept, vld_q[LATENCY-1]})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.data_rvalid_o = vld_q[LATENCY-1];
  assign bus.data_err_o    = err_q[LATENCY-1];
  assign bus.data_rdata_o  = rdata_q[LATENCY-1];
endmodule

// File: tb/tb_obi_data_responder.sv
// Directed bench for obi_data_responder: four instances with different latency/outstanding settings.
module tb_obi_data_responder;
  localparam logic [31:0] B0 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic [3:0]  req_b, we_b, stall_b;
  logic [3:0]  be_b [4];
  logic [31:0] addr_b [4];
  logic [31:0] wd_b [4];
  logic [31:0] rd_w [4];
  logic [3:0]  gnt_w, rv_w, err_w;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  obi_data_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_wire
    assign bus[g].data_req_i   = req_b[g];
    assign bus[g].data_we_i    = we_b[g];
    assign bus[g].data_be_i    = be_b[g];
    assign bus[g].data_addr_i  = addr_b[g];
    assign bus[g].data_wdata_i = wd_b[g];
    assign gnt_w[g]            = bus[g].data_gnt_o;
    assign rv_w[g]             = bus[g].data_rvalid_o;
    assign err_w[g]            = bus[g].data_err_o;
    assign rd_w[g]             = bus[g].data_rdata_o;
  end

  obi_data_responder #(.DEPTH_WORDS(16), .BASE_ADDR(B0), .LATENCY(1), .MAX_OUTSTANDING(2))
    u_dut0 (.clk(clk), .n_reset(rst_n), .stall_i(stall_b[0]), .bus(bus[0]));
  obi_data_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(2), .MAX_OUTSTANDING(3))
    u_dut1 (.clk(clk), .n_reset(rst_n), .stall_i(stall_b[1]), .bus(bus[1]));
  obi_data_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(1))
    u_dut2 (.clk(clk), .n_reset(rst_n), .stall_i(stall_b[2]), .bus(bus[2]));
  obi_data_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(3))
    u_dut3 (.clk(clk), .n_reset(rst3_n), .stall_i(stall_b[3]), .bus(bus[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int u, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_b[u]  = 1'b1;
    we_b[u]   = we;
    be_b[u]   = be;
    addr_b[u] = addr;
    wd_b[u]   = wd;
  endtask

  // Holds the current request until granted (bounded), returning on the negedge after acceptance.
  task automatic wait_gnt(input int u, input string tag);
    int t = 0;
    #1;
    while (!gnt_w[u] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!gnt_w[u]) chk(tag, 32'(gnt_w[u]), 32'h1);
    @(negedge clk);
  endtask

  task automatic preload(input int u, input int n, input logic [31:0] pat);
    for (int i = 0; i < n; i++) begin
      drive(u, 1'b1, 4'hF, 32'(4 * i), pat | 32'(i));
      wait_gnt(u, "preload_gnt");
    end
    req_b[u] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Single transfer on the LATENCY=1 instance: grant in the request cycle, response one cycle later.
  task automatic xfer0(input string tag, input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    drive(0, we, be, addr, wd);
    #1 chk({tag, "_gnt"}, 32'(gnt_w[0]), 32'h1);
    @(negedge clk);
    req_b[0] = 1'b0;
    chk({tag, "_rvalid"}, 32'(rv_w[0]), 32'h1);
    chk({tag, "_rdata"}, rd_w[0], exp_rd);
    chk({tag, "_err"}, 32'(err_w[0]), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [21:0] bp_gnt, bp_rv;
    logic [7:0]  mr_gnt, mr_rv;
    int          rd_idx, rv_n;

    rst_n = 1'b1; rst3_n = 1'b1;
    req_b = '0; we_b = '0; stall_b = '0;
    for (int i = 0; i < 4; i++) begin
      be_b[i] = '0; addr_b[i] = '0; wd_b[i] = '0;
    end
    #3 rst_n = 1'b0; rst3_n = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt_w), 32'h0);
    chk("rst_rvalid", 32'(rv_w), 32'h0);
    chk("rst_err", 32'(err_w), 32'h0);
    chk("rst_rdata", rd_w[0], 32'h0);
    rst_n = 1'b1; rst3_n = 1'b1;
    #1 chk("idle_gnt", 32'(gnt_w), 32'hF);
    @(negedge clk);

    // Basic write/read, partial writes and address decode on the LATENCY=1 instance.
    xfer0("wr_beef",    1'b1, 4'hF,    B0 + 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0);
    xfer0("rd_beef",    1'b0, 4'hF,    B0 + 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);
    xfer0("rd_lowbits", 1'b0, 4'h0,    B0 + 32'h13, 32'h0,         32'hDEAD_BEEF, 1'b0);
    xfer0("wr_full",    1'b1, 4'hF,    B0 + 32'h14, 32'h1122_3344, 32'h0,         1'b0);
    xfer0("wr_part",    1'b1, 4'b0101, B0 + 32'h14, 32'hAABB_CCDD, 32'h0,         1'b0);
    xfer0("rd_part",    1'b0, 4'hF,    B0 + 32'h14, 32'h0,         32'h11BB_33DD, 1'b0);
    xfer0("wr_be0",     1'b1, 4'h0,    B0 + 32'h14, 32'hFFFF_FFFF, 32'h0,         1'b0);
    xfer0("rd_be0",     1'b0, 4'hF,    B0 + 32'h14, 32'h0,         32'h11BB_33DD, 1'b0);
    xfer0("wr_w0",      1'b1, 4'hF,    B0,          32'h0BAD_F00D, 32'h0,         1'b0);
    xfer0("wr_top",     1'b1, 4'hF,    B0 + 32'h3C, 32'h1357_9BDF, 32'h0,         1'b0);
    xfer0("wr_oor",     1'b1, 4'hF,    B0 + 32'h40, 32'hFFFF_FFFF, 32'h0,         1'b1);
    xfer0("rd_oor",     1'b0, 4'hF,    B0 + 32'h40, 32'h0,         32'h0,         1'b1);
    xfer0("rd_below",   1'b0, 4'hF,    B0 - 32'h4,  32'h0,         32'h0,         1'b1);
    xfer0("rd_w0",      1'b0, 4'hF,    B0,          32'h0,         32'h0BAD_F00D, 1'b0);
    xfer0("rd_top",     1'b0, 4'hF,    B0 + 32'h3C, 32'h0,         32'h1357_9BDF, 1'b0);
    @(negedge clk);
    chk("idle_rv0", 32'(rv_w[0]), 32'h0);

    // Streaming: LATENCY=2, MAX_OUTSTANDING=3, eight back-to-back reads.
    preload(1, 8, 32'hC0DE_0000);
    for (int j = 0; j < 11; j++) begin
      if (j >= 2 && j < 10) begin
        chk($sformatf("s_rvalid%0d", j), 32'(rv_w[1]), 32'h1);
        chk($sformatf("s_rdata%0d", j), rd_w[1], 32'hC0DE_0000 | 32'(j - 2));
      end else begin
        chk($sformatf("s_rvalid%0d", j), 32'(rv_w[1]), 32'h0);
      end
      if (j < 8) begin
        drive(1, 1'b0, 4'hF, 32'(4 * j), 32'h0);
        #1 chk($sformatf("s_gnt%0d", j), 32'(gnt_w[1]), 32'h1);
      end else begin
        req_b[1] = 1'b0;
      end
      @(negedge clk);
    end

    // Backpressure: LATENCY=3, MAX_OUTSTANDING=1, then a 5-cycle stall with one read in flight.
    preload(2, 5, 32'hB0B0_0000);
    bp_gnt = 22'((1 << 0) | (1 << 4) | (1 << 8) | (1 << 12) | (1 << 18));
    bp_rv  = 22'((1 << 3) | (1 << 7) | (1 << 11) | (1 << 15) | (1 << 21));
    rd_idx = 0;
    rv_n   = 0;
    for (int c = 0; c < 22; c++) begin
      chk($sformatf("bp_rvalid%0d", c), 32'(rv_w[2]), 32'(bp_rv[c]));
      chk($sformatf("bp_rdata%0d", c), rd_w[2], bp_rv[c] ? (32'hB0B0_0000 | 32'(rv_n)) : 32'h0);
      if (bp_rv[c]) rv_n++;
      stall_b[2] = (c >= 13 && c <= 17);
      if ((c < 12 && rd_idx < 3) || (c >= 12 && rd_idx < 5))
        drive(2, 1'b0, 4'hF, 32'(4 * rd_idx), 32'h0);
      else
        req_b[2] = 1'b0;
      #1 chk($sformatf("bp_gnt%0d", c), 32'(gnt_w[2]), 32'(bp_gnt[c]));
      if (req_b[2] && gnt_w[2]) rd_idx++;
      @(negedge clk);
    end
    req_b[2] = 1'b0;
    stall_b[2] = 1'b0;
    chk("bp_accepts", 32'(rd_idx), 32'd5);

    // Reset mid-flight: two reads in the LATENCY=3 pipe are discarded, not replayed.
    preload(3, 3, 32'h5A5A_0000);
    drive(3, 1'b0, 4'hF, 32'h0, 32'h0);
    #1 chk("mr_gnt_a", 32'(gnt_w[3]), 32'h1);
    @(negedge clk);
    drive(3, 1'b0, 4'hF, 32'h4, 32'h0);
    #1 chk("mr_gnt_b", 32'(gnt_w[3]), 32'h1);
    @(negedge clk);
    req_b[3] = 1'b0;
    rst3_n = 1'b0;
    #1 chk("mr_rst_gnt", 32'(gnt_w[3]), 32'h0);
    chk("mr_rst_rvalid", 32'(rv_w[3]), 32'h0);
    @(negedge clk);
    rst3_n = 1'b1;
    mr_gnt = 8'b1111_0111;
    mr_rv  = 8'b1011_1000;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mr_rvalid%0d", k), 32'(rv_w[3]), 32'(mr_rv[k]));
      if (mr_rv[k])
        chk($sformatf("mr_rdata%0d", k), rd_w[3], 32'h5A5A_0000 | 32'((k == 7) ? 0 : k - 3));
      if (k < 5)
        drive(3, 1'b0, 4'hF, 32'((k < 3) ? 4 * k : 0), 32'h0);
      else
        req_b[3] = 1'b0;
      #1 chk($sformatf("mr_gnt%0d", k), 32'(gnt_w[3]), 32'(mr_gnt[k]));
      @(negedge clk);
    end
    req_b[3] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
